sqrt_dispatch: RTL and testbench

- Operand dispatcher and result collector that sits directly around the `sqrt` core.
- Buffers incoming 16-bit operands in a small FIFO and issues them to the core one at a time.
- Waits for the core's `endop`, captures the 8-bit root, self-checks it, and presents operand and root on a valid/ready output.
- Feeds the core's `valor` input and consumes its `sqrt`/`endop` outputs.

---
 rtl/sqrt_dispatch.sv | 180 ++++++++++++++++++
 tb/tb_sqrt_dispatch.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_dispatch.sv
// Operand dispatcher around the sqrt core: buffers operands in a FIFO, issues one
// at a time, captures and self-checks the root, and returns it on a valid/ready port.
module sqrt_dispatch #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              in_value,
    output logic                     core_start,
    output logic [15:0]              core_valor,
    input  logic                     core_endop,
    input  logic [7:0]               core_sqrt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_value,
    output logic [7:0]               out_root,
    output logic                     out_chk,
    output logic                     out_tmo,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t          state_q, state_d;
    logic [15:0]     mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [15:0]     op_q, op_d;
    logic [15:0]     valor_q, valor_d;
    logic            start_q, start_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            endop_prev_q, endop_prev_d;
    logic            ovalid_q, ovalid_d;
    logic [15:0]     ovalue_q, ovalue_d;
    logic [7:0]      oroot_q, oroot_d;
    logic            ochk_q, ochk_d;
    logic            otmo_q, otmo_d;

    logic            push, pop, capture, timeout, root_ok;
    logic [15:0]     root_lo_sq;
    logic [16:0]     root_hi, root_hi_sq;

    assign in_ready   = (count_q < CW'(DEPTH)) && reset;
    assign push       = in_valid && in_ready;
    assign pop        = (state_q == IDLE) && (count_q != '0);

    // Only a fresh 0->1 edge counts, and never in the cycle the start pulse is out.
    assign capture    = (state_q == WAIT) && !start_q && core_endop && !endop_prev_q;
    assign timeout    = (state_q == WAIT) && (timer_q == TW'(TIMEOUT - 1));

    // (root+1)^2 kept at 17 bits so root 255 yields 65536 rather than wrapping to 0.
    assign root_lo_sq = {8'b0, core_sqrt} * {8'b0, core_sqrt};
    assign root_hi    = {9'b0, core_sqrt} + 17'd1;
    assign root_hi_sq = root_hi * root_hi;
    assign root_ok    = (root_lo_sq <= op_q) && ({1'b0, op_q} < root_hi_sq);

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        op_d         = op_q;
        valor_d      = valor_q;
        start_d      = 1'b0;
        timer_d      = timer_q;
        endop_prev_d = core_endop;
        ovalid_d     = ovalid_q;
        ovalue_d     = ovalue_q;
        oroot_d      = oroot_q;
        ochk_d       = ochk_q;
        otmo_d       = otmo_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    op_d     = mem_q[rd_ptr_q];
                    valor_d  = mem_q[rd_ptr_q];
                    rd_ptr_d = rd_ptr_q + PW'(1);
                    start_d  = 1'b1;
                    timer_d  = '0;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                timer_d = timer_q + TW'(1);
                if (capture) begin
                    oroot_d  = core_sqrt;
                    ovalue_d = op_q;
                    otmo_d   = 1'b0;
                    ochk_d   = !root_ok;
                    ovalid_d = 1'b1;
                    state_d  = HOLD;
                end else if (timeout) begin
                    oroot_d  = '0;
                    ovalue_d = op_q;
                    otmo_d   = 1'b1;
                    ochk_d   = 1'b0;
                    ovalid_d = 1'b1;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    ovalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            op_q         <= '0;
            valor_q      <= '0;
            start_q      <= 1'b0;
            timer_q      <= '0;
            endop_prev_q <= 1'b0;
            ovalid_q     <= 1'b0;
            ovalue_q     <= '0;
            oroot_q      <= '0;
            ochk_q       <= 1'b0;
            otmo_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            op_q         <= op_d;
            valor_q      <= valor_d;
            start_q      <= start_d;
            timer_q      <= timer_d;
            endop_prev_q <= endop_prev_d;
            ovalid_q     <= ovalid_d;
            ovalue_q     <= ovalue_d;
            oroot_q      <= oroot_d;
            ochk_q       <= ochk_d;
            otmo_q       <= otmo_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_value;
        end
    end

    assign core_start = start_q;
    assign core_valor = valor_q;
    assign out_valid  = ovalid_q;
    assign out_value  = ovalue_q;
    assign out_root   = oroot_q;
    assign out_chk    = ochk_q;
    assign out_tmo    = otmo_q;
    assign busy       = (state_q != IDLE);
    assign count      = count_q;

endmodule

// File: tb/tb_sqrt_dispatch.sv
// Bench for sqrt_dispatch: behavioural core model, result scoreboard built from
// plain integer square-root arithmetic, and directed scenarios with literal pins.
module tb_sqrt_dispatch;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic                   clock = 1'b0;
    logic                   reset = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [15:0]            in_value = '0;
    logic                   core_start;
    logic [15:0]            core_valor;
    logic                   core_endop;
    logic [7:0]             core_sqrt;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic [15:0]            out_value;
    logic [7:0]             out_root;
    logic                   out_chk;
    logic                   out_tmo;
    logic                   busy;
    logic [$clog2(DEPTH):0] count;

    always #5 clock = ~clock;

    sqrt_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
        .core_start(core_start), .core_valor(core_valor),
        .core_endop(core_endop), .core_sqrt(core_sqrt),
        .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
        .out_root(out_root), .out_chk(out_chk), .out_tmo(out_tmo),
        .busy(busy), .count(count)
    );

    typedef struct {int value; int root; int chk; int tmo;} res_t;

    res_t exp_q[$];
    res_t log_q[$];
    int   checks = 0;
    int   failures = 0;

    function automatic void check(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endfunction

    function automatic int isqrt(int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    // Core behaviour knobs (stimulus)
    int          fault_val = -1, fault_root = 0, hang_val = -1;
    logic        manual = 1'b0, man_endop = 1'b0;
    logic [7:0]  man_sqrt = '0;
    logic        core_ep = 1'b0;
    logic [7:0]  core_res = '0;
    int          cnt = 0, cop = 0;

    assign core_endop = manual ? man_endop : core_ep;
    assign core_sqrt  = manual ? man_sqrt  : core_res;

    always @(posedge clock) begin
        core_ep <= 1'b0;
        if (core_start) begin
            cnt <= 3;
            cop <= int'(core_valor);
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
            if (cnt == 1 && cop != hang_val) begin
                core_ep  <= 1'b1;
                core_res <= (cop == fault_val) ? 8'(fault_root) : 8'(isqrt(cop));
            end
        end
    end

    function automatic res_t model(int v);
        res_t r;
        r.value = v;
        if (v == hang_val) begin
            r.root = 0; r.chk = 0; r.tmo = 1;
        end else begin
            r.root = (v == fault_val) ? fault_root : isqrt(v);
            r.tmo  = 0;
            r.chk  = (r.root * r.root <= v && v < (r.root + 1) * (r.root + 1)) ? 0 : 1;
        end
        return r;
    endfunction

    // Compare process: scoreboard on handshake, stability while stalled
    res_t cur, prev, e;
    bit   prev_hold = 0;
    bit   seen_full = 0;
    int   starts = 0;

    always begin
        @(negedge clock);
        #1;
        if (!reset) begin
            prev_hold = 0;
        end else begin
            cur.value = int'(out_value); cur.root = int'(out_root);
            cur.chk = int'(out_chk); cur.tmo = int'(out_tmo);
            if (core_start) starts++;
            if (count == DEPTH) begin
                check("in_ready_when_full", int'(in_ready), 0);
                seen_full = 1;
            end
            if (prev_hold) begin
                check("hold_valid", int'(out_valid), 1);
                check("hold_value", cur.value, prev.value);
                check("hold_root", cur.root, prev.root);
                check("hold_chk", cur.chk, prev.chk);
                check("hold_tmo", cur.tmo, prev.tmo);
            end
            prev = cur;
            prev_hold = out_valid && !out_ready;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("res_value", cur.value, e.value);
                    check("res_root", cur.root, e.root);
                    check("res_chk", cur.chk, e.chk);
                    check("res_tmo", cur.tmo, e.tmo);
                end
                log_q.push_back(cur);
            end
        end
    end

    task automatic push(input int v);
        int t = 0;
        in_value = 16'(v);
        in_valid = 1'b1;
        while (!in_ready && t < 300) begin
            @(negedge clock);
            t++;
        end
        if (!in_ready) begin
            check("push_accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(model(v));
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || busy || count != 0 || out_valid) && t < 2000) begin
            @(negedge clock);
            t++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic check_log(input int idx, input int v, input int r, input int c, input int tm);
        if (idx >= log_q.size()) begin
            check("log_missing_entry", log_q.size(), idx + 1);
        end else begin
            check("pin_value", log_q[idx].value, v);
            check("pin_root", log_q[idx].root, r);
            check("pin_chk", log_q[idx].chk, c);
            check("pin_tmo", log_q[idx].tmo, tm);
        end
    endtask

    int t1_v[6] = '{4, 16, 25, 36, 49, 225};
    int t1_r[6] = '{2, 4, 5, 6, 7, 15};
    int bp_v[5] = '{81, 100, 121, 144, 169};
    int s0, c;

    initial begin
        out_ready = 1'b1;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_count", int'(count), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_core_start", int'(core_start), 0);
        check("rst_core_valor", int'(core_valor), 0);
        check("rst_out_value", int'(out_value), 0);
        check("rst_out_root", int'(out_root), 0);
        check("rst_out_chk", int'(out_chk), 0);
        check("rst_out_tmo", int'(out_tmo), 0);
        reset = 1'b1;
        @(negedge clock);
        check("idle_in_ready", int'(in_ready), 1);

        // Back-to-back stream
        log_q.delete(); seen_full = 0;
        for (int i = 0; i < 6; i++) push(t1_v[i]);
        drain("t1_drain");
        check("t1_results", log_q.size(), 6);
        for (int i = 0; i < 6; i++) check_log(i, t1_v[i], t1_r[i], 0, 0);
        check("t1_fifo_filled", int'(seen_full), 1);

        // Boundaries, with issue latency from an empty FIFO
        log_q.delete();
        push(0);
        check("issue_not_yet", int'(core_start), 0);
        @(negedge clock);
        check("issue_start", int'(core_start), 1);
        check("issue_valor", int'(core_valor), 0);
        push(65535);
        push(65025);
        drain("bnd_drain");
        check_log(0, 0, 0, 0, 0);
        check_log(1, 65535, 255, 0, 0);
        check_log(2, 65025, 255, 0, 0);

        log_q.delete();
        fault_val = 65535; fault_root = 254;
        push(65535);
        drain("bnd_fault_drain");
        check_log(0, 65535, 254, 1, 0);

        log_q.delete();
        fault_val = 16; fault_root = 3;
        push(16);
        drain("fault16_drain");
        check_log(0, 16, 3, 1, 0);
        fault_val = -1;

        // Timeout then normal issue
        log_q.delete();
        hang_val = 49;
        push(49);
        push(64);
        c = 0;
        while (!core_start && c < 50) begin @(negedge clock); c++; end
        check("tmo_issue_seen", int'(core_start), 1);
        c = 0;
        while (!out_valid && c < 200) begin @(negedge clock); c++; end
        check("tmo_latency", c, TIMEOUT);
        drain("tmo_drain");
        check_log(0, 49, 0, 0, 1);
        check_log(1, 64, 8, 0, 0);
        hang_val = -1;

        // Backpressure
        log_q.delete();
        out_ready = 1'b0;
        s0 = starts;
        for (int i = 0; i < 5; i++) push(bp_v[i]);
        repeat (20) @(negedge clock);
        check("bp_count", int'(count), DEPTH);
        check("bp_in_ready", int'(in_ready), 0);
        check("bp_out_valid", int'(out_valid), 1);
        check("bp_out_value", int'(out_value), 81);
        check("bp_single_start", starts - s0, 1);
        out_ready = 1'b1;
        drain("bp_drain");
        for (int i = 0; i < 5; i++) check_log(i, bp_v[i], 9 + i, 0, 0);

        // endop held high across issue
        log_q.delete();
        manual = 1'b1; man_endop = 1'b1; man_sqrt = 8'd0;
        repeat (3) @(negedge clock);
        push(36);
        repeat (10) @(negedge clock);
        check("stuck_no_capture", int'(out_valid), 0);
        check("stuck_busy", int'(busy), 1);
        man_endop = 1'b0;
        @(negedge clock);
        man_sqrt = 8'd6; man_endop = 1'b1;
        @(negedge clock);
        man_endop = 1'b0;
        drain("stuck_drain");
        check_log(0, 36, 6, 0, 0);
        manual = 1'b0;

        // Reset while waiting on the core
        log_q.delete();
        hang_val = 25;
        push(25);
        push(100);
        repeat (5) @(negedge clock);
        check("prerst_busy", int'(busy), 1);
        reset = 1'b0;
        @(negedge clock);
        check("midrst_busy", int'(busy), 0);
        check("midrst_count", int'(count), 0);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready", int'(in_ready), 0);
        exp_q.delete();
        hang_val = -1;
        reset = 1'b1;
        @(negedge clock);
        push(36);
        drain("postrst_drain");
        check("postrst_results", log_q.size(), 1);
        check_log(0, 36, 6, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
